cuo_vector_sequencer: RTL and testbench
=======================================

Name: cuo_vector_sequencer

Overview:
- Sits directly upstream of the CuO array controller and also consumes its results.
- Accepts a stream of DAC codes (one vector, delimited by in_last), issues one start pulse per element to the array controller, and waits for each conversion to complete.
- Offset-corrects each ADC result and accumulates the vector into a saturating sum.
- Presents the sum, element count and an error flag on a valid/ready output port, and guards each conversion with a timeout watchdog.

Parameters:
- PRECISION, 12, DAC/ADC code width; must match the array controller.
- ACC_W, 32, accumulator and out_sum width (ACC_W >= PRECISION + 1).
- CNT_W, 16, element counter width.
- TIMEOUT, 64, maximum cycles from ctl_start to the ctl_done rising edge before abort.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream element valid.
- in_ready  out  1  sequencer can accept an element.
- in_data  in  PRECISION  DAC code for this element.
- in_last  in  1  final element of the vector.
- adc_offset  in  PRECISION  offset subtracted from each ADC result; sampled at ACCUM.
- ctl_start  out  1  one-cycle start pulse to the array controller.
- ctl_data  out  PRECISION  DAC code to the controller; held stable from ISSUE until that element leaves WAIT_DONE.
- ctl_result  in  32  controller result; only bits [PRECISION-1:0] are used.
- ctl_done  in  1  controller done; sticky high until the next conversion starts.
- out_valid  out  1  vector result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  saturating sum of corrected samples.
- out_count  out  CNT_W  number of elements consumed, including drained elements; saturates at all-ones.
- out_error  out  1  a timeout occurred in this vector.
- busy  out  1  high in any state other than IDLE with an empty vector.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - in_ready=1.
  - ctl_start=0, ctl_data=0.
  - out_valid=0, out_sum=0, out_count=0, out_error=0.
  - Accumulator, counter, timer, done_q and the error flag are all cleared.
  - Reset mid-operation abandons the vector; the controller is allowed to finish on its own.
- Done edge detection: done_q registers ctl_done every cycle. done_rise = ctl_done & ~done_q. Only done_rise completes a conversion, because ctl_done stays high from the previous conversion.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid: latch in_data into ctl_data and in_last into last_q, increment count, then go to ISSUE.
  - ISSUE:
    - in_ready=0; ctl_start=1 for exactly this cycle; timer cleared.
    - Always goes to WAIT_DONE next.
  - WAIT_DONE:
    - Timer increments each cycle.
    - On done_rise: capture ctl_result[PRECISION-1:0] into sample_q and go to ACCUM.
    - If instead timer reaches TIMEOUT-1: set err_q; if last_q go to OUTPUT, else go to DRAIN.
    - If done_rise and timeout coincide, done_rise wins.
  - ACCUM:
    - corr = sample_q - adc_offset, clamped to 0 if negative (PRECISION bits, unsigned).
    - acc <= acc + corr, saturating at 2^ACC_W-1.
    - Next state is OUTPUT if last_q, else IDLE.
  - DRAIN:
    - in_ready=1; ctl_start stays 0.
    - Each accepted element increments count and is otherwise discarded.
    - On accepting an element with in_last=1, go to OUTPUT.
  - OUTPUT:
    - out_valid=1; in_ready=0.
    - out_sum, out_count and out_error are registered and stable while out_valid && !out_ready.
    - On out_ready: clear acc, count and err_q, then go to IDLE. out_valid falls the next cycle.
- Latency:
  - ctl_start rises 1 cycle after the in_valid handshake.
  - out_valid rises 2 cycles after the done_rise of the last element (ACCUM, then OUTPUT).
- Minimum per-element throughput: handshake + ISSUE + controller latency + ACCUM.
- A single-element vector (in_last on the first element) is legal.
- in_ready is 0 in ISSUE, WAIT_DONE, ACCUM and OUTPUT; upstream must hold its data until the handshake.
- A spurious done_rise outside WAIT_DONE is ignored; done_q still tracks ctl_done.

Test Plan:
- Single-element vector: in_data=0x155, adc_offset=0, controller model returns 0x0A0 → ctl_start pulses once with ctl_data=0x155; out_sum=0xA0, out_count=1, out_error=0.
- Four-element vector: results 100, 200, 300, 400, adc_offset=50 → out_sum=800, out_count=4; exactly 4 ctl_start pulses; out_valid 2 cycles after the last done_rise.
- Clamp and saturation: result 10 with offset 50 → contributes 0. With ACC_W=13, eight results of 0xFFF at offset 0 → out_sum=0x1FFF (saturated).
- Timeout: 3-element vector where the controller never raises done for element 2 → no ctl_start for element 3; element 3 is drained; out_error=1, out_count=3, out_sum=element-1 contribution only.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and out_sum stay stable and in_ready=0; the next vector is accepted only after the out_ready handshake, with acc restarting from 0.
- Reset mid-WAIT_DONE: assert rst for 1 cycle → next cycle in_ready=1, out_valid=0, ctl_start=0; a later stale done_rise from the controller causes no accumulation.

Source files
------------

// File: rtl/cuo_vector_sequencer.sv
// Vector sequencer for the CuO array: issues one conversion per DAC code, offset-corrects
// each ADC result and accumulates the vector into a saturating sum with a timeout watchdog.
module cuo_vector_sequencer #(
    parameter int unsigned PRECISION = 12,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRECISION-1:0] in_data,
    input  logic                 in_last,
    input  logic [PRECISION-1:0] adc_offset,
    output logic                 ctl_start,
    output logic [PRECISION-1:0] ctl_data,
    input  logic [31:0]          ctl_result,
    input  logic                 ctl_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_error,
    output logic                 busy
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitDone,
        StAccum,
        StDrain,
        StOutput
    } state_e;

    state_e               state_q;
    logic [ACC_W-1:0]     acc_q;
    logic [CNT_W-1:0]     count_q;
    logic [TMR_W-1:0]     timer_q;
    logic [PRECISION-1:0] sample_q;
    logic                 done_q;
    logic                 err_q;
    logic                 last_q;

    logic                 done_rise;
    logic                 timeout_hit;
    logic [PRECISION-1:0] corr;
    logic [ACC_W:0]       acc_sum;
    logic [ACC_W-1:0]     acc_next;
    logic [CNT_W-1:0]     count_inc;

    // ctl_done is sticky from the previous conversion, so only its rising edge counts.
    assign done_rise   = ctl_done & ~done_q;
    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));

    always_comb begin
        corr = '0;
        if (sample_q >= adc_offset) begin
            corr = sample_q - adc_offset;
        end
        acc_sum  = {1'b0, acc_q} + {{(ACC_W + 1 - PRECISION){1'b0}}, corr};
        acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
        count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
    end

    assign busy = !((state_q == StIdle) && (count_q == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            sample_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            last_q    <= 1'b0;
            in_ready  <= 1'b1;
            ctl_start <= 1'b0;
            ctl_data  <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_error <= 1'b0;
        end else begin
            done_q    <= ctl_done;
            ctl_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        ctl_data  <= in_data;
                        last_q    <= in_last;
                        count_q   <= count_inc;
                        in_ready  <= 1'b0;
                        ctl_start <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    timer_q <= '0;
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (done_rise) begin
                        sample_q <= ctl_result[PRECISION-1:0];
                        state_q  <= StAccum;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        if (last_q) begin
                            out_valid <= 1'b1;
                            out_sum   <= acc_q;
                            out_count <= count_q;
                            out_error <= 1'b1;
                            state_q   <= StOutput;
                        end else begin
                            in_ready <= 1'b1;
                            state_q  <= StDrain;
                        end
                    end
                end
                StAccum: begin
                    acc_q <= acc_next;
                    if (last_q) begin
                        out_valid <= 1'b1;
                        out_sum   <= acc_next;
                        out_count <= count_q;
                        out_error <= err_q;
                        state_q   <= StOutput;
                    end else begin
                        in_ready <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                StDrain: begin
                    // Remaining elements of an aborted vector are counted but never issued.
                    if (in_valid) begin
                        count_q <= count_inc;
                        if (in_last) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= acc_q;
                            out_count <= count_inc;
                            out_error <= err_q;
                            state_q   <= StOutput;
                        end
                    end
                end
                StOutput: begin
                    if (out_ready) begin
                        acc_q     <= '0;
                        count_q   <= '0;
                        err_q     <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cuo_vector_sequencer.sv
// Directed bench for cuo_vector_sequencer with a behavioural array-controller model.
module tb_cuo_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        in_last;
    logic [11:0] adc_offset;
    logic        ctl_start;
    logic [11:0] ctl_data;
    logic [31:0] ctl_result;
    logic        ctl_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [15:0] out_count;
    logic        out_error;
    logic        busy;

    // Narrow-accumulator instance sharing all inputs, used for saturation.
    logic        s_in_ready;
    logic        s_ctl_start;
    logic [11:0] s_ctl_data;
    logic        s_out_valid;
    logic [12:0] s_out_sum;
    logic [15:0] s_out_count;
    logic        s_out_error;
    logic        s_busy;

    int checks = 0;
    int errors = 0;

    logic [11:0] results[$];
    logic [11:0] issued[$];
    int hang_at = -1;
    int start_cnt = 0;
    int last_done_cyc = 0;
    int cyc = 0;

    cuo_vector_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .adc_offset (adc_offset),
        .ctl_start  (ctl_start),
        .ctl_data   (ctl_data),
        .ctl_result (ctl_result),
        .ctl_done   (ctl_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_error  (out_error),
        .busy       (busy)
    );

    cuo_vector_sequencer #(.ACC_W(13)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .adc_offset (adc_offset),
        .ctl_start  (s_ctl_start),
        .ctl_data   (s_ctl_data),
        .ctl_result (ctl_result),
        .ctl_done   (ctl_done),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_sum    (s_out_sum),
        .out_count  (s_out_count),
        .out_error  (s_out_error),
        .busy       (s_busy)
    );

    always #5 clk = ~clk;

    // Controller model: done rises 3 cycles after start and stays high until the next start.
    initial begin : ctl_model
        int  cd;
        bit  pend;
        cd = 0;
        pend = 0;
        ctl_done = 1'b0;
        ctl_result = 32'd0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (ctl_start === 1'b1) begin
                start_cnt++;
                issued.push_back(ctl_data);
                ctl_done = 1'b0;
                cd = 3;
                pend = 1;
            end else if (pend) begin
                cd--;
                if (cd == 0) begin
                    pend = 0;
                    if (start_cnt != hang_at && results.size() > 0) begin
                        ctl_result = {20'd0, results.pop_front()};
                        ctl_done = 1'b1;
                        last_done_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic send(input logic [11:0] d, input logic l, output bit ok);
        logic rdy;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                ok = 1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept_out;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (in_ready !== 1'b1 || ctl_start !== 1'b0 || ctl_data !== 12'h000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: in_ready=%b ctl_start=%b ctl_data=%h busy=%b expected 1 0 000 0",
                     in_ready, ctl_start, ctl_data, busy);
        end
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 32'd0 || out_count !== 16'd0 || out_error !== 1'b0
            || s_out_sum !== 13'd0) begin
            errors++;
            $display("FAIL reset_out: valid=%b sum=%h count=%h err=%b ssum=%h expected all zero",
                     out_valid, out_sum, out_count, out_error, s_out_sum);
        end
    endtask

    task automatic test_single;
        bit ok;
        int s0;
        results = '{12'h0A0};
        adc_offset = 12'd0;
        issued.delete();
        s0 = start_cnt;
        send(12'h155, 1'b1, ok);
        checks++;
        if (!ok || ctl_start !== 1'b1 || ctl_data !== 12'h155) begin
            errors++;
            $display("FAIL single_issue: ok=%0d ctl_start=%b ctl_data=%h expected 1 1 155",
                     ok, ctl_start, ctl_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ctl_start !== 1'b0 || ctl_data !== 12'h155) begin
            errors++;
            $display("FAIL single_pulse: ctl_start=%b ctl_data=%h expected 0 155", ctl_start, ctl_data);
        end
        wait_out(ok);
        checks++;
        if (!ok || out_sum !== 32'h0A0 || out_count !== 16'd1 || out_error !== 1'b0) begin
            errors++;
            $display("FAIL single_result: ok=%0d sum=%h count=%0d err=%b expected 1 a0 1 0",
                     ok, out_sum, out_count, out_error);
        end
        checks++;
        if (start_cnt - s0 != 1 || issued.size() != 1) begin
            errors++;
            $display("FAIL single_starts: got %0d starts expected 1", start_cnt - s0);
        end else if (issued[0] !== 12'h155) begin
            errors++;
            $display("FAIL single_starts: issued code %h expected 155", issued[0]);
        end
        accept_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_four;
        bit ok;
        bit all_ok;
        int s0;
        results = '{12'd100, 12'd200, 12'd300, 12'd400};
        adc_offset = 12'd50;
        s0 = start_cnt;
        all_ok = 1;
        for (int i = 0; i < 4; i++) begin
            send(12'h010 + 12'(i), (i == 3), ok);
            all_ok &= ok;
        end
        wait_out(ok);
        checks++;
        if (!all_ok || !ok || out_sum !== 32'd800 || out_count !== 16'd4 || out_error !== 1'b0) begin
            errors++;
            $display("FAIL four_result: ok=%0d/%0d sum=%0d count=%0d err=%b expected 800 4 0",
                     all_ok, ok, out_sum, out_count, out_error);
        end
        checks++;
        if (start_cnt - s0 != 4) begin
            errors++;
            $display("FAIL four_starts: got %0d expected 4", start_cnt - s0);
        end
        checks++;
        if (cyc - last_done_cyc != 2) begin
            errors++;
            $display("FAIL four_latency: got %0d cycles expected 2", cyc - last_done_cyc);
        end
        accept_out();
    endtask

    task automatic test_clamp_saturation;
        bit ok;
        bit all_ok;
        results = '{12'd10, 12'd60};
        adc_offset = 12'd50;
        all_ok = 1;
        send(12'h001, 1'b0, ok);
        all_ok &= ok;
        send(12'h002, 1'b1, ok);
        all_ok &= ok;
        wait_out(ok);
        checks++;
        if (!all_ok || !ok || out_sum !== 32'd10 || out_count !== 16'd2) begin
            errors++;
            $display("FAIL clamp: ok=%0d/%0d sum=%0d count=%0d expected 10 2",
                     all_ok, ok, out_sum, out_count);
        end
        accept_out();

        results = '{8{12'hFFF}};
        adc_offset = 12'd0;
        all_ok = 1;
        for (int i = 0; i < 8; i++) begin
            send(12'hFFF, (i == 7), ok);
            all_ok &= ok;
        end
        wait_out(ok);
        checks++;
        if (!all_ok || !ok || s_out_valid !== 1'b1 || s_out_sum !== 13'h1FFF
            || s_out_count !== 16'd8) begin
            errors++;
            $display("FAIL saturate: valid=%b sum=%h count=%0d expected 1 1fff 8",
                     s_out_valid, s_out_sum, s_out_count);
        end
        checks++;
        if (out_sum !== 32'h7FF8) begin
            errors++;
            $display("FAIL wide_sum: got %h expected 7ff8", out_sum);
        end
        accept_out();
    endtask

    task automatic test_timeout;
        bit ok;
        bit all_ok;
        int s0;
        results = '{12'h123};
        adc_offset = 12'd0;
        s0 = start_cnt;
        hang_at = start_cnt + 2;
        all_ok = 1;
        send(12'h111, 1'b0, ok);
        all_ok &= ok;
        send(12'h222, 1'b0, ok);
        all_ok &= ok;
        send(12'h333, 1'b1, ok);
        all_ok &= ok;
        wait_out(ok);
        checks++;
        if (!all_ok || !ok || out_error !== 1'b1 || out_count !== 16'd3 || out_sum !== 32'h123) begin
            errors++;
            $display("FAIL timeout_result: ok=%0d/%0d err=%b count=%0d sum=%h expected 1 3 123",
                     all_ok, ok, out_error, out_count, out_sum);
        end
        checks++;
        if (start_cnt - s0 != 2) begin
            errors++;
            $display("FAIL timeout_starts: got %0d expected 2", start_cnt - s0);
        end
        hang_at = -1;
        accept_out();
    endtask

    task automatic test_back_to_back;
        bit ok;
        bit stable;
        int s0;
        results = '{12'h200};
        adc_offset = 12'd0;
        send(12'h0C0, 1'b1, ok);
        wait_out(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_valid: out_valid=%b expected 1", out_valid);
        end
        in_valid = 1'b1;
        in_data  = 12'h7AA;
        in_last  = 1'b1;
        s0 = start_cnt;
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_sum !== 32'h200 || in_ready !== 1'b0) begin
                stable = 0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!stable || out_valid !== 1'b1 || out_sum !== 32'h200 || start_cnt != s0) begin
            errors++;
            $display("FAIL bp_hold: valid=%b sum=%h in_ready=%b starts=%0d expected 1 200 0 0",
                     out_valid, out_sum, in_ready, start_cnt - s0);
        end
        accept_out();
        results = '{12'h010};
        send(12'h0C1, 1'b1, ok);
        wait_out(ok);
        checks++;
        if (!ok || out_sum !== 32'h010 || out_count !== 16'd1) begin
            errors++;
            $display("FAIL bp_next: ok=%0d sum=%h count=%0d expected 1 10 1", ok, out_sum, out_count);
        end
        accept_out();
    endtask

    task automatic test_reset_mid;
        bit ok;
        results = '{12'h300};
        adc_offset = 12'd0;
        send(12'h0AB, 1'b1, ok);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ctl_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: in_ready=%b out_valid=%b ctl_start=%b busy=%b expected 1 0 0 0",
                     in_ready, out_valid, ctl_start, busy);
        end
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_stale: out_valid=%b busy=%b in_ready=%b expected 0 0 1",
                     out_valid, busy, in_ready);
        end
        results = '{12'h050};
        send(12'h0AC, 1'b1, ok);
        wait_out(ok);
        checks++;
        if (!ok || out_sum !== 32'h050 || out_count !== 16'd1 || out_error !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: ok=%0d sum=%h count=%0d err=%b expected 1 50 1 0",
                     ok, out_sum, out_count, out_error);
        end
        accept_out();
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 12'd0;
        in_last    = 1'b0;
        adc_offset = 12'd0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_single();
        test_four();
        test_clamp_saturation();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
